ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one synchronous RAM port (the CPU-side port of the dual-port RAM) between
//  NUM_REQ requesters, e.g. the ALU load/store path and a VRAM fill/DMA engine.
//  Round-robin arbitration with an optional bounded lock for bursts; read data
//  returns to the issuing requester after the RAM's fixed read latency.
// PARAMETERS
//  NUM_REQ     2   number of requesters (2..4)
//  ADDR_W      16  RAM address width
//  DATA_W      16  RAM data width
//  RD_LATENCY  1   clocks from address edge to valid ram_q (1 or 2)
//  MAX_LOCK    8   max consecutive locked grants before forced release (>=1)
// PORTS
//  clock      in   1                 single clock (same clock as the RAM port)
//  clear      in   1                 asynchronous reset, active-low
//  req_valid  in   NUM_REQ           request present, per requester
//  req_we     in   NUM_REQ           1 = write, 0 = read
//  req_lock   in   NUM_REQ           hold grant after this transfer (burst)
//  req_addr   in   NUM_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W    packed write data
//  req_ready  out  NUM_REQ           one-hot grant; transfer when valid&ready
//  rsp_valid  out  NUM_REQ           read data valid, one-hot, one cycle
//  rsp_rdata  out  DATA_W            read data (shared, qualified by rsp_valid)
//  ram_address out ADDR_W            to RAM address port
//  ram_data   out  DATA_W            to RAM data port
//  ram_wren   out  1                 to RAM write enable
//  ram_q      in   DATA_W            from RAM q
// BEHAVIOUR
//  - Reset (clear=0, async): rr pointer=0, lock owner none, lock count=0, response
//    pipeline flushed, run flag=0. While run=0: req_ready=0, rsp_valid=0, ram_wren=0,
//    ram_address=0, ram_data=0. run sets on first clock edge after clear releases.
//  - Grant (combinational, same cycle): if a lock owner exists and its req_valid=1 it
//    wins; otherwise first valid requester searching from pointer upward, wrapping.
//    No valid requester -> req_ready=0, ram_wren=0, ram_address/ram_data=0.
//  - req_ready asserts only for the winner and only when req_valid is high; requester
//    holds addr/data/we stable until accepted.
//  - Accepted transfer drives ram_address/ram_data from winner, ram_wren=req_we.
//    Writes produce no response.
//  - Read accepted at edge N -> rsp_valid[winner]=1, rsp_rdata=ram_q at cycle
//    N+RD_LATENCY. Tag pipeline is RD_LATENCY deep; back-to-back reads pipeline fully,
//    responses in issue order. rsp_rdata=0 when no rsp_valid.
//  - Pointer update on accept, not locked: pointer = winner+1 mod NUM_REQ.
//  - Lock: accept with req_lock=1 -> owner=winner, count+1; pointer unchanged.
//    Accept with req_lock=0, or owner drops req_valid -> owner cleared, count=0,
//    pointer = owner+1. count reaching MAX_LOCK -> owner cleared, count=0,
//    pointer = owner+1 (owner loses priority for that arbitration even if req_lock=1).
//  - Read-after-write same address, consecutive cycles: RAM order preserved (one port,
//    serialised), read returns newly written value.
//  - Reset mid-operation: in-flight read tags discarded; no rsp_valid after reset.
// STRUCTURE
//  - Package ram_arb_pkg: localparam defaults (ADDR_W, DATA_W), grant index width
//    function, rsp tag struct {valid, id}.
//  - Sub-module rr_pick: combinational rotate-priority one-hot picker (req, pointer ->
//    grant, index); lock override, counters and tag pipeline stay in the top.
// TESTING
//  1 RAM[0x0010]=0xBEEF; req0 read 0x0010 alone -> req_ready[0] same cycle,
//    rsp_valid[0]=1 with 0xBEEF exactly 1 cycle later, rsp_valid[1]=0 throughout.
//  2 req0,req1 both valid continuously 4 cycles, pointer=0 -> grants 0,1,0,1.
//  3 MAX_LOCK=4, req1 locked reads, req0 always valid -> grants 1,1,1,1,0,1...
//  4 req0 write 0x1234 @0x0100, req1 read 0x0100 next cycle -> rsp 0x1234 to req1.
//  5 read accepted then clear=0 next cycle for 2 cycles -> rsp_valid never 1,
//    req_ready=0 until first edge after release, then normal grant from pointer 0.
//  6 RD_LATENCY=2, req0 reads 0x0..0x3 back-to-back -> 4 responses, in order,
//    2 cycles after each accept, data matches preloaded RAM.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default RAM address and data widths
//   TAG_ID_W                : requester id width in a response tag (covers up to 4 requesters)
//   rsp_tag_t               : one stage of the read-response tag pipeline
//   idx_w()                 : width of a requester index for a given requester count
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int TAG_ID_W   = 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rsp_tag_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter, all requesters packed side by side.
//   req_valid/req_we/req_lock : per-requester request, write flag, burst lock
//   req_addr/req_wdata        : packed, requester i at [i*W +: W]
//   req_ready                 : one-hot grant back to the requesters
//   rsp_valid/rsp_rdata       : one-hot read response and shared read data
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   ptr   : index searched first; the search wraps upward from here
//   grant : one-hot winner (all zero when nothing requests)
//   idx   : winner index
//   any   : at least one request present
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            grant[k] = any && (idx == IW'(k));
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between NUM_REQ requesters.
// Round-robin grant with an optional bounded burst lock; read data is returned
// to the issuing requester RD_LATENCY clocks after the accepting edge.
//   clock, clear          : clock and asynchronous active-low reset
//   bus                   : requester bus (slave side)
//   ram_address/ram_data/ram_wren : RAM port drive
//   ram_q                 : RAM read data
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 8
) (
    input  logic              clock,
    input  logic              clear,
    ram_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic               run;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic               owner_vld;
    logic [CW-1:0]      lock_cnt;
    rsp_tag_t           tag_q [RD_LATENCY];

    logic [IW-1:0]      eff_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               owner_hold;
    logic [IW-1:0]      win;
    logic               accept;
    logic [CW-1:0]      cnt_inc;
    logic               lock_max;
    rsp_tag_t           tag_in;
    rsp_tag_t           rsp_tag;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    // While a lock is held the round-robin search starts just past the owner, so an
    // owner that drops its request hands over exactly as if its lock had ended.
    assign eff_ptr = owner_vld ? wrap_inc(owner) : ptr;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (eff_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        owner_hold  = owner_vld && bus.req_valid[owner];
        win         = owner_hold ? owner : pick_idx;
        accept      = run && (owner_hold || pick_any);

        bus.req_ready = '0;
        ram_address   = '0;
        ram_data      = '0;
        ram_wren      = 1'b0;
        if (accept) begin
            if (owner_hold) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.req_ready[i] = (owner == IW'(i));
                end
            end else begin
                bus.req_ready = pick_grant;
            end
            ram_address = bus.req_addr[win*ADDR_W +: ADDR_W];
            ram_data    = bus.req_wdata[win*DATA_W +: DATA_W];
            ram_wren    = bus.req_we[win];
        end

        // A fresh locker starts counting from zero; only the current owner continues.
        cnt_inc  = (owner_hold ? lock_cnt : '0) + 1'b1;
        lock_max = (cnt_inc >= CW'(MAX_LOCK));

        tag_in.valid = accept && !bus.req_we[win];
        tag_in.id    = TAG_ID_W'(win);

        rsp_tag = tag_q[RD_LATENCY-1];
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = rsp_tag.valid && (rsp_tag.id == TAG_ID_W'(i));
        end
        bus.rsp_rdata = rsp_tag.valid ? ram_q : '0;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            run       <= 1'b0;
            ptr       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            lock_cnt  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            run      <= 1'b1;
            tag_q[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            if (accept) begin
                if (bus.req_lock[win] && !lock_max) begin
                    owner     <= win;
                    owner_vld <= 1'b1;
                    lock_cnt  <= cnt_inc;
                end else begin
                    owner_vld <= 1'b0;
                    lock_cnt  <= '0;
                    ptr       <= wrap_inc(win);
                end
            end else if (owner_vld && !owner_hold) begin
                owner_vld <= 1'b0;
                lock_cnt  <= '0;
                ptr       <= wrap_inc(owner);
            end
        end
    end
endmodule
